// File: rtl/point_stream_assembler.sv
// Groups DIMS serial coordinates into packed points and buffers them in a DEPTH-entry FIFO.
// Optional running bounding box of committed points when POINT_ASM_BBOX_EN is defined.
module point_stream_assembler #(
  parameter int DIMS    = 2,
  parameter int COORD_W = 32,
  parameter int DEPTH   = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [COORD_W-1:0]        in_coord,
  input  logic                      in_last,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DIMS*COORD_W-1:0]   out_point,
  output logic [$clog2(DEPTH):0]    out_count,
  output logic                      err_short,
  output logic                      err_long
`ifdef POINT_ASM_BBOX_EN
  ,
  output logic                      bbox_valid,
  output logic [DIMS*COORD_W-1:0]   bbox_min,
  output logic [DIMS*COORD_W-1:0]   bbox_max
`endif
);

  localparam int PW    = DIMS * COORD_W;
  localparam int IDX_W = (DIMS > 1) ? $clog2(DIMS) : 1;
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIMS - 1);

  if (DIMS < 1 || DIMS > 8) begin : g_bad_dims
    $error("point_stream_assembler: DIMS must be in 1..8");
  end
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("point_stream_assembler: DEPTH must be a power of 2, >= 2");
  end

  logic [IDX_W-1:0] idx_q, idx_d;
  logic [PW-1:0]    asm_q, asm_d;
  logic [PW-1:0]    mem_q [DEPTH];
  logic [PW-1:0]    mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             out_valid_q, out_valid_d;
  logic             err_short_q, err_short_d;
  logic             err_long_q, err_long_d;

  logic             last_slot, full, pop, accept, commit;
  logic [PW-1:0]    point_new;

`ifdef POINT_ASM_BBOX_EN
  logic             bbox_valid_q, bbox_valid_d;
  logic [PW-1:0]    bbox_min_q, bbox_min_d;
  logic [PW-1:0]    bbox_max_q, bbox_max_d;
`endif

  always_comb begin
    idx_d       = idx_q;
    asm_d       = asm_q;
    mem_d       = mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    err_short_d = 1'b0;
    err_long_d  = 1'b0;

    last_slot = (idx_q == LAST_IDX);
    full      = (count_q == CNT_W'(DEPTH));
    pop       = out_valid_q && out_ready;
    // The last coordinate of a point may enter a full FIFO if the head leaves this cycle.
    in_ready  = !last_slot || !full || pop;
    accept    = in_valid && in_ready;
    commit    = accept && last_slot;

    point_new = asm_q;
    for (int k = 0; k < DIMS; k++) begin
      if (idx_q == IDX_W'(k)) point_new[k*COORD_W +: COORD_W] = in_coord;
    end

    if (accept) begin
      if (commit) begin
        mem_d[wr_ptr_q] = point_new;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        idx_d           = '0;
        asm_d           = '0;
        err_long_d      = !in_last;
      end else if (in_last) begin
        idx_d       = '0;
        asm_d       = '0;
        err_short_d = 1'b1;
      end else begin
        asm_d = point_new;
        idx_d = idx_q + IDX_W'(1);
      end
    end

    if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);

    case ({commit, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    out_valid_d = (count_d != '0);
  end

`ifdef POINT_ASM_BBOX_EN
  always_comb begin
    bbox_valid_d = bbox_valid_q;
    bbox_min_d   = bbox_min_q;
    bbox_max_d   = bbox_max_q;
    if (commit) begin
      bbox_valid_d = 1'b1;
      if (!bbox_valid_q) begin
        bbox_min_d = point_new;
        bbox_max_d = point_new;
      end else begin
        for (int k = 0; k < DIMS; k++) begin
          if ($signed(point_new[k*COORD_W +: COORD_W]) < $signed(bbox_min_q[k*COORD_W +: COORD_W]))
            bbox_min_d[k*COORD_W +: COORD_W] = point_new[k*COORD_W +: COORD_W];
          if ($signed(point_new[k*COORD_W +: COORD_W]) > $signed(bbox_max_q[k*COORD_W +: COORD_W]))
            bbox_max_d[k*COORD_W +: COORD_W] = point_new[k*COORD_W +: COORD_W];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bbox_valid_q <= 1'b0;
      bbox_min_q   <= '0;
      bbox_max_q   <= '0;
    end else begin
      bbox_valid_q <= bbox_valid_d;
      bbox_min_q   <= bbox_min_d;
      bbox_max_q   <= bbox_max_d;
    end
  end

  assign bbox_valid = bbox_valid_q;
  assign bbox_min   = bbox_min_q;
  assign bbox_max   = bbox_max_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q       <= '0;
      asm_q       <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      err_short_q <= 1'b0;
      err_long_q  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      idx_q       <= idx_d;
      asm_q       <= asm_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
      err_short_q <= err_short_d;
      err_long_q  <= err_long_d;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
    end
  end

  assign out_valid = out_valid_q;
  assign out_point = mem_q[rd_ptr_q];
  assign out_count = count_q;
  assign err_short = err_short_q;
  assign err_long  = err_long_q;

endmodule

// File: tb/tb_point_stream_assembler.sv
// Scoreboard bench: DUT 0 is DIMS=2, DUT 1 is DIMS=3; monitors compare popped points against queues.
module tb_point_stream_assembler;

  logic             clk;
  logic [1:0]       rst, in_valid, in_last, out_ready;
  logic [1:0][31:0] in_coord;
  logic [1:0]       in_ready, out_valid, err_short, err_long;
  logic [63:0]      a_point;
  logic [95:0]      b_point;
  logic [2:0]       a_count, b_count;
`ifdef POINT_ASM_BBOX_EN
  logic             a_bbox_valid, b_bbox_valid;
  logic [63:0]      a_bbox_min, a_bbox_max;
  logic [95:0]      b_bbox_min, b_bbox_max;
`endif

  int n_chk = 0;
  int n_err = 0;
  int obs_short [2];
  int obs_long  [2];
  logic [95:0] exp_a [$];
  logic [95:0] exp_b [$];

  point_stream_assembler #(.DIMS(2), .COORD_W(32), .DEPTH(4)) u_a (
    .clk(clk), .rst(rst[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_coord(in_coord[0]), .in_last(in_last[0]), .out_valid(out_valid[0]),
    .out_ready(out_ready[0]), .out_point(a_point), .out_count(a_count),
    .err_short(err_short[0]), .err_long(err_long[0])
`ifdef POINT_ASM_BBOX_EN
    , .bbox_valid(a_bbox_valid), .bbox_min(a_bbox_min), .bbox_max(a_bbox_max)
`endif
  );

  point_stream_assembler #(.DIMS(3), .COORD_W(32), .DEPTH(4)) u_b (
    .clk(clk), .rst(rst[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_coord(in_coord[1]), .in_last(in_last[1]), .out_valid(out_valid[1]),
    .out_ready(out_ready[1]), .out_point(b_point), .out_count(b_count),
    .err_short(err_short[1]), .err_long(err_long[1])
`ifdef POINT_ASM_BBOX_EN
    , .bbox_valid(b_bbox_valid), .bbox_min(b_bbox_min), .bbox_max(b_bbox_max)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [95:0] pack2(input int c0, input int c1);
    return {32'b0, c1, c0};
  endfunction

  function automatic logic [95:0] pack3(input int c0, input int c1, input int c2);
    return {c2, c1, c0};
  endfunction

  // Monitors: a pop happens at the next rising edge whenever valid and ready are seen here.
  always @(negedge clk) begin
    if (!rst[0]) begin
      if (err_short[0]) obs_short[0]++;
      if (err_long[0])  obs_long[0]++;
      if (out_valid[0] && out_ready[0]) begin
        if (exp_a.size() == 0) check("a_unexpected_point", {32'b0, a_point}, 96'hx);
        else check("a_point", {32'b0, a_point}, exp_a.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (!rst[1]) begin
      if (err_short[1]) obs_short[1]++;
      if (err_long[1])  obs_long[1]++;
      if (out_valid[1] && out_ready[1]) begin
        if (exp_b.size() == 0) check("b_unexpected_point", b_point, 96'hx);
        else check("b_point", b_point, exp_b.pop_front());
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 just after the coordinate was accepted.
  task automatic send(input int d, input int c, input logic l);
    int t;
    in_valid[d] = 1'b1;
    in_coord[d] = c;
    in_last[d]  = l;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!in_ready[d] && t < 50);
    if (!in_ready[d]) check("send_timeout", 96'(in_ready[d]), 96'd1);
    @(posedge clk); #1;
    in_valid[d] = 1'b0;
    in_last[d]  = 1'b0;
  endtask

  task automatic wait_empty(input int d);
    int t;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (((d == 0) ? a_count : b_count) != 3'd0 && t < 50);
    check("drain_count", 96'((d == 0) ? a_count : b_count), 96'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    obs_short[0] = 0; obs_short[1] = 0;
    obs_long[0]  = 0; obs_long[1]  = 0;
    rst = 2'b11; in_valid = '0; in_last = '0; out_ready = '0; in_coord = '0;
    repeat (2) @(posedge clk);
    #1 rst = 2'b00;

    @(negedge clk);
    check("reset_in_ready", 96'(in_ready), 96'b11);
    check("reset_out_valid", 96'(out_valid), 96'b00);
    check("reset_count_a", 96'(a_count), 96'd0);
    check("reset_count_b", 96'(b_count), 96'd0);
    check("reset_point_a", {32'b0, a_point}, 96'd0);
    check("reset_point_b", b_point, 96'd0);
    check("reset_err", 96'({err_short, err_long}), 96'd0);
    @(posedge clk); #1;

    // Basic DIMS=2 point, latency 1
    send(0, 3, 1'b0);
    send(0, 4, 1'b1);
    exp_a.push_back(pack2(3, 4));
    @(negedge clk);
    check("t1_out_valid", 96'(out_valid[0]), 96'd1);
    check("t1_count", 96'(a_count), 96'd1);
    check("t1_point", {32'b0, a_point}, pack2(3, 4));
    @(posedge clk); #1;
    out_ready[0] = 1'b1;
    wait_empty(0);

    // DIMS=3 fill to full, back-pressure, then simultaneous commit and pop
    for (int p = 0; p < 4; p++) begin
      send(1, 3*p + 1, 1'b0);
      send(1, 3*p + 2, 1'b0);
      send(1, 3*p + 3, 1'b1);
      exp_b.push_back(pack3(3*p + 1, 3*p + 2, 3*p + 3));
    end
    @(negedge clk);
    check("t2_count_full", 96'(b_count), 96'd4);
    check("t2_ready_mid", 96'(in_ready[1]), 96'd1);
    @(posedge clk); #1;
    send(1, 13, 1'b0);
    send(1, 14, 1'b0);
    in_valid[1] = 1'b1; in_coord[1] = 32'd15; in_last[1] = 1'b1;
    exp_b.push_back(pack3(13, 14, 15));
    @(negedge clk);
    check("t2_backpressure", 96'(in_ready[1]), 96'd0);
    check("t2_count_hold", 96'(b_count), 96'd4);
    @(posedge clk); #1;
    out_ready[1] = 1'b1;
    @(negedge clk);
    check("t2_ready_on_pop", 96'(in_ready[1]), 96'd1);
    @(posedge clk); #1;
    in_valid[1] = 1'b0; in_last[1] = 1'b0; out_ready[1] = 1'b0;
    @(negedge clk);
    check("t2_commit_pop_count", 96'(b_count), 96'd4);
    @(posedge clk); #1;
    out_ready[1] = 1'b1;
    wait_empty(1);

    // Short point dropped, then a good point
    send(1, 5, 1'b0);
    send(1, 6, 1'b1);
    @(posedge clk); #1;
    check("t3_err_short", 96'(obs_short[1]), 96'd1);
    check("t3_count", 96'(b_count), 96'd0);
    send(1, 6, 1'b0);
    send(1, 7, 1'b0);
    send(1, 8, 1'b1);
    exp_b.push_back(pack3(6, 7, 8));
    wait_empty(1);
    check("t3_no_err_long", 96'(obs_long[1]), 96'd0);

    // Long point still committed
    send(0, 1, 1'b0);
    send(0, 2, 1'b0);
    exp_a.push_back(pack2(1, 2));
    @(posedge clk); #1;
    check("t4_err_long", 96'(obs_long[0]), 96'd1);
    wait_empty(0);
    check("t4_no_err_short", 96'(obs_short[0]), 96'd0);

    // Reset mid-point with two points queued
    out_ready[0] = 1'b0;
    send(0, 9, 1'b0);  send(0, 10, 1'b1);
    send(0, 11, 1'b0); send(0, 12, 1'b1);
    send(0, 13, 1'b0);
    check("t5_count_before", 96'(a_count), 96'd2);
    rst[0] = 1'b1;
    @(posedge clk); #1;
    rst[0] = 1'b0;
    exp_a.delete();
    @(negedge clk);
    check("t5_out_valid", 96'(out_valid[0]), 96'd0);
    check("t5_count", 96'(a_count), 96'd0);
    @(posedge clk); #1;
    out_ready[0] = 1'b1;
    send(0, 3, 1'b0);
    send(0, 4, 1'b1);
    exp_a.push_back(pack2(3, 4));
    wait_empty(0);

`ifdef POINT_ASM_BBOX_EN
    rst[0] = 1'b1;
    @(posedge clk); #1;
    rst[0] = 1'b0;
    check("bbox_reset_valid", 96'(a_bbox_valid), 96'd0);
    send(0, -1, 1'b0); send(0, 5, 1'b1);
    exp_a.push_back(pack2(-1, 5));
    send(0, 7, 1'b0);  send(0, -3, 1'b1);
    exp_a.push_back(pack2(7, -3));
    @(negedge clk);
    check("bbox_valid", 96'(a_bbox_valid), 96'd1);
    check("bbox_min", {32'b0, a_bbox_min}, pack2(-1, -3));
    check("bbox_max", {32'b0, a_bbox_max}, pack2(7, 5));
    @(posedge clk); #1;
    wait_empty(0);
`endif

    repeat (3) @(posedge clk);
    check("queue_a_drained", 96'(exp_a.size()), 96'd0);
    check("queue_b_drained", 96'(exp_b.size()), 96'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
